// File: rtl/train_phase_sequencer.sv
// train_phase_sequencer
//   Sequences the systolic array through FP -> BP -> WG for one or more
//   layers per run. Each run phase is followed by a PE clear window. An
//   inference-only run executes FP alone for each layer. Phase lengths, stride,
//   layer count and mode are captured when a run starts and held until it ends.
//
// Ports
//   clk              clock, rising edge
//   fsm_rst          asynchronous active-high reset
//   start            run request, sampled only in IDLE
//   stride           0: stride 1, 1: stride 2 (captured at start)
//   infer_only       1: FP only per layer (captured at start)
//   fp_len/bp_len/wg_len   in_en cycles per phase, 0 skips the phase
//   num_layers       layers per run, 0 behaves as 1
//   busy             high in every state except IDLE
//   done             one-cycle pulse in DONE
//   phase            00 IDLE/DONE, 01 FP, 10 BP, 11 WG (held through that CLR)
//   in_en            array input enable
//   pe_clr           PE accumulator clear
//   mux_sel          {select1,select0,select_m3,select_m2,select_m1,select_m0}
//   inpref_mode      input prefetcher mode
//   inpref_out_mode  input prefetcher output mode
//   en_cutting       {en_cutting1,en_cutting0}
//   layer_idx        current layer, 0-based
//   parity           stride-2 column parity
//
// state | meaning
// IDLE  | waiting for start
// FP    | forward pass, in_en high
// BP    | backward pass, in_en high
// WG    | weight gradient, in_en high
// CLR   | pe_clr window after the phase held in clr_of
// DONE  | one-cycle completion pulse
module train_phase_sequencer #(
   parameter int CNT_W   = 6,
   parameter int LAYER_W = 4,
   parameter int CLR_CYC = 1
) (
   input  logic               clk,
   input  logic               fsm_rst,
   input  logic               start,
   input  logic               stride,
   input  logic               infer_only,
   input  logic [CNT_W-1:0]   fp_len,
   input  logic [CNT_W-1:0]   bp_len,
   input  logic [CNT_W-1:0]   wg_len,
   input  logic [LAYER_W-1:0] num_layers,
   output logic               busy,
   output logic               done,
   output logic [1:0]         phase,
   output logic               in_en,
   output logic               pe_clr,
   output logic [5:0]         mux_sel,
   output logic [1:0]         inpref_mode,
   output logic [2:0]         inpref_out_mode,
   output logic [1:0]         en_cutting,
   output logic [LAYER_W-1:0] layer_idx,
   output logic               parity
);

   typedef enum logic [2:0] {
      ST_IDLE, ST_FP, ST_BP, ST_WG, ST_CLR, ST_DONE
   } state_t;

   state_t             state, state_nxt, clr_of, eff;
   logic [CNT_W-1:0]   cnt, run_len;
   logic [CNT_W-1:0]   fp_q, bp_q, wg_q;
   logic               stride_q, infer_q;
   logic [LAYER_W-1:0] num_q, layer_nxt;
   logic               last_layer;

   // First phase of a layer with a non-zero length; ST_DONE when every
   // phase of the layer is empty (then every layer is empty).
   function automatic state_t first_phase(input logic [CNT_W-1:0] f,
                                          input logic [CNT_W-1:0] b,
                                          input logic [CNT_W-1:0] w,
                                          input logic inf);
      state_t r;
      r = ST_DONE;
      if (f != '0)
         r = ST_FP;
      else if (!inf && b != '0)
         r = ST_BP;
      else if (!inf && w != '0)
         r = ST_WG;
      return r;
   endfunction

   // Phase following p within the same layer; ST_DONE marks end of layer.
   function automatic state_t phase_after(input state_t p,
                                          input logic [CNT_W-1:0] b,
                                          input logic [CNT_W-1:0] w,
                                          input logic inf);
      state_t r;
      r = ST_DONE;
      if (!inf) begin
         if (p == ST_FP && b != '0)
            r = ST_BP;
         else if ((p == ST_FP || p == ST_BP) && w != '0)
            r = ST_WG;
      end
      return r;
   endfunction

   assign last_layer = (num_q == '0) ? (layer_idx == '0)
                                     : (layer_idx == num_q - LAYER_W'(1));

   always_comb begin
      state_nxt = state;
      layer_nxt = layer_idx;
      run_len   = '0;
      case (state)
         ST_FP:   run_len = fp_q;
         ST_BP:   run_len = bp_q;
         ST_WG:   run_len = wg_q;
         default: run_len = '0;
      endcase
      case (state)
         ST_IDLE:
            if (start)
               state_nxt = first_phase(fp_len, bp_len, wg_len, infer_only);
         ST_FP, ST_BP, ST_WG:
            if (cnt == run_len - CNT_W'(1))
               state_nxt = ST_CLR;
         ST_CLR:
            if (cnt == CNT_W'(CLR_CYC - 1)) begin
               state_nxt = phase_after(clr_of, bp_q, wg_q, infer_q);
               if (state_nxt == ST_DONE && !last_layer) begin
                  layer_nxt = layer_idx + LAYER_W'(1);
                  state_nxt = first_phase(fp_q, bp_q, wg_q, infer_q);
               end
            end
         ST_DONE: begin
            state_nxt = ST_IDLE;
            layer_nxt = '0;
         end
         default: state_nxt = ST_IDLE;
      endcase
   end

   always_ff @(posedge clk or posedge fsm_rst) begin
      if (fsm_rst) begin
         state     <= ST_IDLE;
         clr_of    <= ST_FP;
         cnt       <= '0;
         fp_q      <= '0;
         bp_q      <= '0;
         wg_q      <= '0;
         stride_q  <= 1'b0;
         infer_q   <= 1'b0;
         num_q     <= '0;
         layer_idx <= '0;
         parity    <= 1'b0;
      end else begin
         state     <= state_nxt;
         layer_idx <= layer_nxt;
         if (state_nxt != state) begin
            cnt    <= '0;
            parity <= 1'b0;
         end else begin
            cnt <= cnt + CNT_W'(1);
            if (stride_q && (state == ST_FP || state == ST_BP || state == ST_WG))
               parity <= ~parity;
         end
         if (state == ST_IDLE && start) begin
            fp_q     <= fp_len;
            bp_q     <= bp_len;
            wg_q     <= wg_len;
            stride_q <= stride;
            infer_q  <= infer_only;
            num_q    <= num_layers;
         end
         if (state_nxt == ST_CLR && state != ST_CLR)
            clr_of <= state;
      end
   end

   // CLR presents the outputs of the phase it follows.
   assign eff = (state == ST_CLR) ? clr_of : state;

   always_comb begin
      busy            = (state != ST_IDLE);
      done            = (state == ST_DONE);
      in_en           = (state == ST_FP) || (state == ST_BP) || (state == ST_WG);
      pe_clr          = (state == ST_CLR);
      phase           = 2'b00;
      mux_sel         = 6'b000001;
      inpref_mode     = 2'b01;
      inpref_out_mode = 3'b000;
      en_cutting      = 2'b00;
      case (eff)
         ST_FP: begin
            phase           = 2'b01;
            mux_sel         = stride_q ? 6'b010010 : 6'b010001;
            inpref_mode     = stride_q ? 2'b00 : 2'b01;
            inpref_out_mode = stride_q ? 3'b010 : 3'b000;
            en_cutting      = 2'b01;
         end
         ST_BP: begin
            phase           = 2'b10;
            mux_sel         = stride_q ? 6'b000001 : 6'b010001;
            inpref_mode     = stride_q ? 2'b10 : 2'b11;
            inpref_out_mode = stride_q ? 3'b100 : 3'b000;
            en_cutting      = stride_q ? 2'b10 : 2'b00;
         end
         ST_WG: begin
            phase           = 2'b11;
            mux_sel         = stride_q ? 6'b111110 : 6'b111101;
            inpref_mode     = stride_q ? 2'b10 : 2'b11;
            inpref_out_mode = stride_q ? 3'b011 : 3'b001;
            en_cutting      = 2'b00;
         end
         default: ;
      endcase
   end

endmodule
